// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch buffer: controller state encodings,
// the buffer entry layout {pc, inst} and a sizing helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        IFB_IDLE  = 2'd0,
        IFB_WAIT  = 2'd1,
        IFB_DRAIN = 2'd2
    } ifb_state_t;

    localparam int IFB_DEF_ADDRESS_WIDTH = 32;
    localparam int IFB_DEF_DATA_WIDTH    = 32;

    // Entry layout at default widths; parameterised modules mirror this field order.
    typedef struct packed {
        logic [IFB_DEF_ADDRESS_WIDTH-1:0] pc;
        logic [IFB_DEF_DATA_WIDTH-1:0]    inst;
    } ifb_entry_t;

    // Occupancy counter must represent 0..DEPTH inclusive.
    function automatic int ifb_count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ifb_fifo.sv
// Circular FIFO for fetched instructions: synchronous push/pop/clear with count,
// full and empty flags. DEPTH must be a power of two so pointers wrap naturally.
module ifb_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                              i_Clk,
    input  logic                              i_Reset_n,
    input  logic                              i_Clear,
    input  logic                              i_Push,
    input  logic [WIDTH-1:0]                  i_Push_Data,
    input  logic                              i_Pop,
    output logic [WIDTH-1:0]                  o_Head,
    output logic [ifb_count_width(DEPTH)-1:0] o_Count,
    output logic                              o_Full,
    output logic                              o_Empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = ifb_count_width(DEPTH);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_en;
    logic             pop_en;

    assign push_en = i_Push && !i_Clear && !o_Full;
    assign pop_en  = i_Pop  && !i_Clear && !o_Empty;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_Clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; validity comes from count, and
    // a resettable array would cost a reset net on every bit for no benefit.
    always_ff @(posedge i_Clk) begin
        if (push_en) mem[wr_ptr] <= i_Push_Data;
    end

    assign o_Head  = mem[rd_ptr];
    assign o_Count = count;
    assign o_Full  = (count == FULL_COUNT);
    assign o_Empty = (count == '0);

endmodule

// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer: single-outstanding memory request controller feeding a
// small FIFO towards decode. Define IFB_BYPASS_EN to forward a response straight to
// decode in the same cycle when the buffer is empty.
module inst_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 4
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset_n,
    input  logic [ADDRESS_WIDTH-1:0] i_PC,
    input  logic                     i_Flush,
    output logic                     o_Stall,
    output logic                     o_Mem_Req,
    output logic [ADDRESS_WIDTH-1:0] o_Mem_Addr,
    input  logic                     i_Mem_Ack,
    input  logic                     i_Mem_Valid,
    input  logic [DATA_WIDTH-1:0]    i_Mem_Data,
    output logic                     o_Inst_Valid,
    output logic [DATA_WIDTH-1:0]    o_Inst,
    output logic [ADDRESS_WIDTH-1:0] o_Inst_PC,
    input  logic                     i_Inst_Ready
);

    localparam int CNT_W = ifb_count_width(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_COUNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0]    inst;
    } entry_t;

    ifb_state_t               state_q;
    ifb_state_t               state_d;
    logic [ADDRESS_WIDTH-1:0] pending_pc_q;
    logic                     started_q;
    logic                     mem_req;
    logic                     req_accepted;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [CNT_W-1:0]         fifo_count;
    logic                     bypass_hit;
    logic                     bypass_take;
    entry_t                   head;
    entry_t                   push_entry;

`ifdef IFB_BYPASS_EN
    assign bypass_hit  = (state_q == IFB_WAIT) && fifo_empty && i_Mem_Valid && !i_Flush;
    assign bypass_take = bypass_hit && i_Inst_Ready;
`else
    assign bypass_hit  = 1'b0;
    assign bypass_take = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        fifo_push = 1'b0;
        case (state_q)
            IFB_IDLE: begin
                // Space check uses the registered count; a same-cycle pop is not credited.
                mem_req = started_q && !i_Flush && (fifo_count < DEPTH_COUNT);
                if (mem_req && i_Mem_Ack) state_d = IFB_WAIT;
            end
            IFB_WAIT: begin
                if (i_Flush) begin
                    state_d = i_Mem_Valid ? IFB_IDLE : IFB_DRAIN;
                end else if (i_Mem_Valid) begin
                    fifo_push = !bypass_take && !fifo_full;
                    state_d   = IFB_IDLE;
                end
            end
            IFB_DRAIN: begin
                // A flush here keeps waiting: the abandoned response is still in flight.
                if (i_Mem_Valid) state_d = IFB_IDLE;
            end
            default: state_d = IFB_IDLE;
        endcase
    end

    assign req_accepted = mem_req && i_Mem_Ack;
    assign fifo_pop     = i_Inst_Ready && !fifo_empty;
    assign push_entry   = '{pc: pending_pc_q, inst: i_Mem_Data};

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q      <= IFB_IDLE;
            pending_pc_q <= '0;
            started_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            started_q <= 1'b1;
            if (req_accepted) pending_pc_q <= i_PC;
        end
    end

    ifb_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_Clk       (i_Clk),
        .i_Reset_n   (i_Reset_n),
        .i_Clear     (i_Flush),
        .i_Push      (fifo_push),
        .i_Push_Data (push_entry),
        .i_Pop       (fifo_pop),
        .o_Head      (head),
        .o_Count     (fifo_count),
        .o_Full      (fifo_full),
        .o_Empty     (fifo_empty)
    );

    assign o_Stall    = !(req_accepted || i_Flush);
    assign o_Mem_Req  = mem_req;
    assign o_Mem_Addr = i_PC;

`ifdef IFB_BYPASS_EN
    assign o_Inst_Valid = !fifo_empty || bypass_hit;
    assign o_Inst       = !fifo_empty ? head.inst : (bypass_hit ? i_Mem_Data : '0);
    assign o_Inst_PC    = !fifo_empty ? head.pc   : (bypass_hit ? pending_pc_q : '0);
`else
    // Head is masked while empty so unwritten storage never reaches decode.
    assign o_Inst_Valid = !fifo_empty;
    assign o_Inst       = fifo_empty ? '0 : head.inst;
    assign o_Inst_PC    = fifo_empty ? '0 : head.pc;
`endif

endmodule
